datapath_seq_ctrl: RTL and testbench

Multi-cycle sequencer that drives the single-cycle `datapath` control inputs from a 32-bit MIPS instruction.
- Accepts one instruction at a time over a valid/ready handshake.
- Decodes R-type, `lw` and `sw`.
- Steps the datapath through DECODE/EXEC/MEM/WB phases so that each register-file write and each memory write happens in exactly one well-defined cycle.
- Sits between the instruction source and the `datapath` instance; its control outputs connect 1:1 to the datapath's same-named inputs.

---
 rtl/datapath_seq_ctrl.sv | 78 +++++++
 tb/tb_datapath_seq_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/datapath_seq_ctrl.sv
// datapath_seq_ctrl: multi-cycle sequencer driving datapath controls from a latched MIPS instruction
module datapath_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr_in,
  input  logic             mem_ready,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             MemRead,
  output logic [2:0]       ALUControl,
  output logic [25:0]      Inst,
  output logic             done,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
  state_t state_q, state_d;
  logic [31:0] ir_q;
  logic [CNT_W-1:0] retired_q;
  logic is_r, is_lw, is_sw, r_ok, legal, ctl, fin;
  logic [2:0] alu_r;
  assign is_r  = ir_q[31:26] == 6'b000000;
  assign is_lw = ir_q[31:26] == 6'b100011;
  assign is_sw = ir_q[31:26] == 6'b101011;
  // funct decode: unknown funct codes leave r_ok low and make the instruction illegal
  always_comb begin
    alu_r = ir_q[5:0] == 6'b100000 ? 3'b101 :
            ir_q[5:0] == 6'b100010 ? 3'b110 :
            ir_q[5:0] == 6'b100100 ? 3'b000 :
            ir_q[5:0] == 6'b100101 ? 3'b001 :
            ir_q[5:0] == 6'b101010 ? 3'b111 : 3'b000;
    r_ok  = ir_q[5:0] inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  end
  assign legal = (is_r && r_ok) || is_lw || is_sw;
  // next phase; MEM holds until the memory reports ready
  always_comb begin
    state_d = state_q == IDLE   ? (instr_valid ? DECODE : IDLE) :
              state_q == DECODE ? (legal ? EXEC : IDLE) :
              state_q == EXEC   ? (is_r ? WB : MEM) :
              state_q == MEM    ? (mem_ready ? (is_lw ? WB : IDLE) : MEM) : IDLE;
  end
  assign fin = state_q == WB || (state_q == MEM && is_sw && mem_ready);
  // state, instruction register and retired counter; ir only loads on an accepted handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && instr_valid) ir_q <= instr_in;
      if (fin) retired_q <= retired_q + CNT_W'(1);
    end
  end
  // every output is forced low while rst is high so an abort never issues a write or done
  assign ctl         = !rst && state_q != IDLE && legal;
  assign instr_ready = !rst && state_q == IDLE;
  assign busy        = !rst && state_q != IDLE;
  assign illegal     = !rst && state_q == DECODE && !legal;
  assign done        = illegal || (!rst && fin);
  assign RegDst      = ctl && is_r;
  assign ALUSrc      = ctl && !is_r;
  assign MemToReg    = ctl && is_r;
  assign RegWrite    = ctl && state_q == WB;
  assign MemRead     = ctl && is_lw && (state_q == MEM || state_q == WB);
  assign MemWrite    = ctl && is_sw && state_q == MEM && mem_ready;
  assign ALUControl  = !ctl ? 3'b000 : is_r ? alu_r : 3'b101;
  assign Inst        = rst ? 26'd0 : ir_q[25:0];
  assign retired     = rst ? '0 : retired_q;
endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// tb_datapath_seq_ctrl: randomized check of the sequencer against a per-instruction phase-list model
module tb_datapath_seq_ctrl;
  logic clk = 1'b0;
  logic rst, instr_valid, mem_ready;
  logic [31:0] instr_in;
  logic instr_ready, RegDst, RegWrite, ALUSrc, MemWrite, MemToReg, MemRead, done, illegal, busy;
  logic [2:0] ALUControl;
  logic [25:0] Inst;
  logic [3:0] retired;
  logic [38:0] outvec;
  int errs = 0;
  int checks = 0;
  logic [31:0] last_ir;
  int ret;

  datapath_seq_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_in(instr_in), .mem_ready(mem_ready), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemToReg(MemToReg), .MemRead(MemRead),
    .ALUControl(ALUControl), .Inst(Inst), .done(done), .illegal(illegal), .busy(busy),
    .retired(retired)
  );

  always #5 clk = ~clk;

  assign outvec = {instr_ready, busy, done, illegal, RegDst, RegWrite, ALUSrc,
                   MemWrite, MemToReg, MemRead, ALUControl, Inst};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // instruction class from the opcode/funct tables: 0 R-type, 1 lw, 2 sw, 3 illegal
  function automatic int kind_of(input logic [31:0] w);
    if (w[31:26] == 6'h23) return 1;
    if (w[31:26] == 6'h2b) return 2;
    if (w[31:26] != 6'h00) return 3;
    return (w[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) ? 0 : 3;
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] w);
    case (kind_of(w))
      1, 2: return 3'b101;
      0: case (w[5:0])
           6'h20: return 3'b101;
           6'h22: return 3'b110;
           6'h24: return 3'b000;
           6'h25: return 3'b001;
           default: return 3'b111;
         endcase
      default: return 3'b000;
    endcase
  endfunction

  // expected outputs in phase ph (0 idle, 1 decode, 2 exec, 3 mem, 4 wb) while holding instruction w
  function automatic logic [38:0] expect_vec(input int ph, input logic [31:0] w, input bit mr);
    int k = kind_of(w);
    bit on = ph != 0 && k != 3;
    bit bad = ph == 1 && k == 3;
    bit last = ph == 4 || (ph == 3 && k == 2 && mr);
    return {ph == 0, ph != 0, bad || last, bad,
            on && k == 0, on && ph == 4, on && k != 0, on && k == 2 && ph == 3 && mr,
            on && k == 0, on && k == 1 && (ph == 3 || ph == 4),
            on ? alu_of(w) : 3'b000, w[25:0]};
  endfunction

  task automatic tick(input string tag, input logic [38:0] e);
    @(negedge clk);
    check({tag, ":ctl"}, 64'(outvec), 64'(e));
    check({tag, ":ret"}, 64'(retired), 64'(ret % 16));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      instr_valid = 1'b0;
      instr_in = $urandom;
      mem_ready = 1'($urandom);
      tick("gap", expect_vec(0, last_ir, 1'b0));
    end
  endtask

  // one instruction: handshake in IDLE, then the phase list the rules give, with stalls in MEM
  task automatic run(input string tag, input logic [31:0] w, input int stalls);
    int k = kind_of(w);
    int ph[$];
    bit mq[$];
    instr_valid = 1'b1;
    instr_in = w;
    mem_ready = 1'($urandom);
    tick({tag, ":accept"}, expect_vec(0, last_ir, 1'b0));
    last_ir = w;
    ph.push_back(1); mq.push_back(1'($urandom));
    if (k != 3) begin ph.push_back(2); mq.push_back(1'($urandom)); end
    if (k == 0) begin ph.push_back(4); mq.push_back(1'($urandom)); end
    if (k == 1 || k == 2) begin
      for (int i = 0; i < stalls; i++) begin ph.push_back(3); mq.push_back(1'b0); end
      ph.push_back(3); mq.push_back(1'b1);
      if (k == 1) begin ph.push_back(4); mq.push_back(1'($urandom)); end
    end
    for (int i = 0; i < ph.size(); i++) begin
      instr_valid = 1'($urandom);
      instr_in = $urandom;
      mem_ready = mq[i];
      tick($sformatf("%s:c%0d", tag, i + 1), expect_vec(ph[i], w, mq[i]));
    end
    if (k != 3) ret++;
    instr_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int s = $urandom_range(0, 9);
    logic [5:0] fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    if (s < 5) begin
      w[31:26] = 6'h00;
      w[5:0] = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn[$urandom_range(0, 4)];
    end else if (s < 7) w[31:26] = 6'h23;
    else if (s < 9) w[31:26] = 6'h2b;
    else w[31:26] = 6'($urandom);
    return w;
  endfunction

  initial begin
    ret = 0;
    last_ir = '0;
    rst = 1'b1;
    instr_valid = 1'b1;
    instr_in = 32'hFFFF_FFFF;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset:out", 64'(outvec), 64'd0);
      check("reset:ret", 64'(retired), 64'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    instr_valid = 1'b0;
    tick("post_reset", expect_vec(0, 32'd0, 1'b0));
    run("add", 32'h0043_0820, 0);
    run("lw", 32'h8C41_0000, 2);
    run("sw", 32'hAC41_0000, 0);
    run("add_b2b", 32'h0043_0820, 0);
    run("addi", 32'h2041_0005, 0);
    run("badfn", 32'h0043_0821, 0);
    idle_gap(1);
    instr_valid = 1'b1;
    instr_in = 32'h8C41_0000;
    tick("abort:accept", expect_vec(0, last_ir, 1'b0));
    instr_valid = 1'b0;
    tick("abort:decode", expect_vec(1, 32'h8C41_0000, 1'b1));
    rst = 1'b1;
    ret = 0;
    last_ir = '0;
    @(negedge clk);
    check("abort:exec", 64'(outvec), 64'd0);
    check("abort:ret", 64'(retired), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 24; n++) run("wrap", 32'h0043_0820, 0);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 2));
      run("rand", rand_instr(), $urandom_range(0, 3));
    end
    idle_gap(1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
